// File: rtl/prim_subreg_cdc_dst_if.sv
// Register-path signals between the destination-domain endpoint and its surroundings.
// Signal names carry the endpoint's point of view (_i = into the endpoint, _o = out of it).
interface prim_subreg_cdc_dst_if #(
    parameter int DW = 32
);
    logic          req_i;
    logic [DW-1:0] wdata_i;
    logic          ack_o;
    logic          de_i;
    logic [DW-1:0] d_i;
    logic [DW-1:0] q_o;
    logic          qe_o;
    logic [DW-1:0] ds_o;
    logic          upd_req_o;
    logic          upd_ack_i;

    // Handshakes: req_i/ack_o is four-phase, ack_o mirrors req_i one cycle late;
    // upd_req_o/upd_ack_i is four-phase, upd_req_o holds until upd_ack_i rises,
    // and the next request waits until upd_ack_i has fallen again.
    modport slave (
        input  req_i, wdata_i, de_i, d_i, upd_ack_i,
        output ack_o, q_o, qe_o, ds_o, upd_req_o
    );

    modport master (
        output req_i, wdata_i, de_i, d_i, upd_ack_i,
        input  ack_o, q_o, qe_o, ds_o, upd_req_o
    );
endinterface

// File: rtl/prim_subreg_cdc_dst.sv
// Destination-domain register endpoint: applies handshaked software writes, arbitrates them
// against hardware writes, and publishes a stable read-back copy with a four-phase update request.
module prim_subreg_cdc_dst #(
    parameter int            DW            = 32,
    parameter logic [DW-1:0] RESVAL        = '0,
    parameter int            UPDATE_PERIOD = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    prim_subreg_cdc_dst_if.slave  bus,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e        r_state;
    logic          r_req_q;
    logic          r_qe;
    logic [DW-1:0] r_q;
    logic [DW-1:0] r_ds;
    logic          r_pending;
    logic          r_upd_req;

    logic          w_commit;
    logic          w_hw_set;
    logic          w_per_set;
    logic          w_serve;

    assign w_commit = bus.req_i & ~r_req_q;
    // Software wins a collision, so the hardware write only counts without a commit.
    assign w_hw_set = bus.de_i & ~w_commit & (bus.d_i != r_q);
    assign w_serve  = (r_state == ST_IDLE) & r_pending;

    generate
        if (UPDATE_PERIOD > 0) begin : g_period
            localparam int            CW         = $clog2(UPDATE_PERIOD) + 1;
            localparam logic [CW-1:0] CNT_RELOAD = CW'(UPDATE_PERIOD - 1);
            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_cnt <= CNT_RELOAD;
                end else if (r_cnt == '0) begin
                    r_cnt <= CNT_RELOAD;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            assign w_per_set = (r_cnt == '0);
        end else begin : g_no_period
            assign w_per_set = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_req_q   <= 1'b0;
            r_qe      <= 1'b0;
            r_q       <= RESVAL;
            r_pending <= 1'b0;
        end else begin
            r_req_q <= bus.req_i;
            r_qe    <= w_commit;
            if (w_commit) begin
                r_q <= bus.wdata_i;
            end else if (bus.de_i) begin
                r_q <= bus.d_i;
            end
            // A new change arriving while the old one is consumed stays pending.
            r_pending <= w_hw_set | w_per_set | (r_pending & ~w_serve);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_upd_req <= 1'b0;
            r_ds      <= RESVAL;
        end else begin
            // The source ignores updates while its own write is in flight, so a commit may
            // overwrite the copy in any state.
            if (w_commit) begin
                r_ds <= bus.wdata_i;
            end else if (w_serve) begin
                r_ds <= r_q;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_pending) begin
                        r_upd_req <= 1'b1;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.upd_ack_i) begin
                        r_upd_req <= 1'b0;
                        r_state   <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (!bus.upd_ack_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_upd_req <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack_o     = r_req_q;
    assign bus.q_o       = r_q;
    assign bus.qe_o      = r_qe;
    assign bus.ds_o      = r_ds;
    assign bus.upd_req_o = r_upd_req;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_prim_subreg_cdc_dst.sv
// Bench for prim_subreg_cdc_dst: two instances (periodic update of 8 and periodic disabled)
// driven with shared directed and random stimulus, checked every cycle against a reference model.
module tb_prim_subreg_cdc_dst;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        de;
    logic [31:0] wdata;
    logic [31:0] d;
    logic        ack0;
    logic        ack1;
    logic        auto0;
    logic [1:0]  dbg0;
    logic [1:0]  dbg1;

    int checks = 0;
    int errors = 0;

    // Reference model state, one slot per instance.
    int          per     [2] = '{8, 0};
    logic [31:0] m_q     [2];
    logic [31:0] m_ds    [2];
    logic        m_qe    [2];
    logic        m_reqd  [2];
    logic        m_pend  [2];
    logic        m_ureq  [2];
    logic        m_drop  [2];
    int          m_age   [2];

    prim_subreg_cdc_dst_if #(.DW(32)) bus0 ();
    prim_subreg_cdc_dst_if #(.DW(32)) bus1 ();

    assign bus0.req_i     = req;
    assign bus0.wdata_i   = wdata;
    assign bus0.de_i      = de;
    assign bus0.d_i       = d;
    assign bus0.upd_ack_i = ack0;
    assign bus1.req_i     = req;
    assign bus1.wdata_i   = wdata;
    assign bus1.de_i      = de;
    assign bus1.d_i       = d;
    assign bus1.upd_ack_i = ack1;

    prim_subreg_cdc_dst #(.DW(32), .RESVAL(32'h0), .UPDATE_PERIOD(8)) dut0 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus0.slave),
        .o_dbg_state (dbg0)
    );

    prim_subreg_cdc_dst #(.DW(32), .RESVAL(32'h0), .UPDATE_PERIOD(0)) dut1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus1.slave),
        .o_dbg_state (dbg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m_q[i]    = 32'h0;
        m_ds[i]   = 32'h0;
        m_qe[i]   = 1'b0;
        m_reqd[i] = 1'b0;
        m_pend[i] = 1'b0;
        m_ureq[i] = 1'b0;
        m_drop[i] = 1'b0;
        m_age[i]  = 0;
    endtask

    // One clock of the register's rules: software write on a new request, else hardware write;
    // a real hardware change or a period expiry marks the copy stale; a stale copy is refreshed
    // and announced only when no update handshake is open.
    task automatic model_step(input int i, input logic ack);
        logic        commit;
        logic        hw;
        logic        chg;
        logic        fire;
        logic        serve;
        logic [31:0] nq;
        logic [31:0] nds;
        commit = req && !m_reqd[i];
        hw     = de && !commit;
        chg    = hw && (d != m_q[i]);
        fire   = (per[i] != 0) && (m_age[i] == per[i] - 1);
        serve  = !m_ureq[i] && !m_drop[i] && m_pend[i];
        nq     = commit ? wdata : (hw ? d : m_q[i]);
        nds    = commit ? wdata : (serve ? m_q[i] : m_ds[i]);
        if (serve) begin
            m_ureq[i] = 1'b1;
        end else if (m_ureq[i] && ack) begin
            m_ureq[i] = 1'b0;
            m_drop[i] = 1'b1;
        end else if (m_drop[i] && !ack) begin
            m_drop[i] = 1'b0;
        end
        m_pend[i] = chg || fire || (m_pend[i] && !serve);
        if (per[i] != 0) m_age[i] = fire ? 0 : m_age[i] + 1;
        m_q[i]    = nq;
        m_ds[i]   = nds;
        m_qe[i]   = commit;
        m_reqd[i] = req;
    endtask

    task automatic cmp_dut(input string p, input int i, input logic [31:0] q, input logic [31:0] ds,
                           input logic qe, input logic ack, input logic ureq);
        chk({p, ".q"}, q, m_q[i]);
        chk({p, ".ds"}, ds, m_ds[i]);
        chk1({p, ".qe"}, qe, m_qe[i]);
        chk1({p, ".ack"}, ack, m_reqd[i]);
        chk1({p, ".upd_req"}, ureq, m_ureq[i]);
    endtask

    task automatic cmp_all();
        cmp_dut("d0", 0, bus0.q_o, bus0.ds_o, bus0.qe_o, bus0.ack_o, bus0.upd_req_o);
        cmp_dut("d1", 1, bus1.q_o, bus1.ds_o, bus1.qe_o, bus1.ack_o, bus1.upd_req_o);
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) model_reset(i);
            else        model_step(i, (i == 0) ? ack0 : ack1);
        end
        #1;
        cmp_all();
        if (auto0) ack0 = bus0.upd_req_o;
    endtask

    initial begin
        int rise0;
        int rise1;
        logic prev0;
        logic prev1;

        rst_n = 1'b0;
        req   = 1'b0;
        de    = 1'b0;
        wdata = 32'h0;
        d     = 32'h0;
        ack0  = 1'b0;
        ack1  = 1'b0;
        auto0 = 1'b1;
        model_reset(0);
        model_reset(1);

        // Reset state
        #3;
        cmp_all();
        chk("rst.q", bus1.q_o, 32'h0);
        chk1("rst.upd_req", bus0.upd_req_o, 1'b0);
        cycle();
        cycle();
        @(negedge clk);
        rst_n = 1'b1;

        // Software write held for six cycles
        repeat (4) cycle();
        req   = 1'b1;
        wdata = 32'hA5A5_0001;
        cycle();
        chk("sw.q", bus1.q_o, 32'hA5A5_0001);
        chk("sw.ds", bus1.ds_o, 32'hA5A5_0001);
        chk1("sw.qe_first", bus1.qe_o, 1'b1);
        chk1("sw.ack_rise", bus1.ack_o, 1'b1);
        cycle();
        chk1("sw.qe_second", bus1.qe_o, 1'b0);
        repeat (4) begin
            cycle();
            chk1("sw.ack_held", bus1.ack_o, 1'b1);
            chk1("sw.no_recommit", bus1.qe_o, 1'b0);
        end
        req = 1'b0;
        cycle();
        chk1("sw.ack_fall", bus1.ack_o, 1'b0);
        chk("sw.q_kept", bus1.q_o, 32'hA5A5_0001);

        // Hardware change and full update handshake
        de = 1'b1;
        d  = 32'h1234;
        cycle();
        de = 1'b0;
        chk("hw.q", bus1.q_o, 32'h1234);
        chk1("hw.upd_req_early", bus1.upd_req_o, 1'b0);
        cycle();
        chk1("hw.upd_req", bus1.upd_req_o, 1'b1);
        chk("hw.ds", bus1.ds_o, 32'h1234);
        cycle();
        chk1("hw.upd_req_hold", bus1.upd_req_o, 1'b1);
        ack1 = 1'b1;
        cycle();
        chk1("hw.upd_req_drop", bus1.upd_req_o, 1'b0);
        cycle();
        ack1 = 1'b0;
        cycle();
        de = 1'b1;
        repeat (2) cycle();
        de = 1'b0;
        repeat (3) begin
            cycle();
            chk1("hw.same_no_upd", bus1.upd_req_o, 1'b0);
        end

        // Collision: software commit beats hardware write
        req   = 1'b1;
        wdata = 32'h55;
        de    = 1'b1;
        d     = 32'hAA;
        cycle();
        de = 1'b0;
        chk("col.q", bus1.q_o, 32'h55);
        chk1("col.qe", bus1.qe_o, 1'b1);
        repeat (2) begin
            cycle();
            chk1("col.no_upd", bus1.upd_req_o, 1'b0);
        end
        req = 1'b0;
        cycle();

        // Change arriving during an open handshake
        de = 1'b1;
        d  = 32'h1;
        cycle();
        de = 1'b0;
        cycle();
        chk1("pend.upd_req1", bus1.upd_req_o, 1'b1);
        chk("pend.ds1", bus1.ds_o, 32'h1);
        de = 1'b1;
        d  = 32'h2;
        cycle();
        de = 1'b0;
        chk("pend.q2", bus1.q_o, 32'h2);
        chk("pend.ds_hold_req", bus1.ds_o, 32'h1);
        ack1 = 1'b1;
        cycle();
        chk1("pend.upd_drop", bus1.upd_req_o, 1'b0);
        chk("pend.ds_hold_drop", bus1.ds_o, 32'h1);
        ack1 = 1'b0;
        cycle();
        chk("pend.ds_hold_idle", bus1.ds_o, 32'h1);
        chk1("pend.upd_low", bus1.upd_req_o, 1'b0);
        cycle();
        chk1("pend.upd_req2", bus1.upd_req_o, 1'b1);
        chk("pend.ds2", bus1.ds_o, 32'h2);

        // Asynchronous reset while in REQ with a change pending
        de = 1'b1;
        d  = 32'h3;
        cycle();
        de = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        cmp_all();
        chk1("arst.upd_req", bus1.upd_req_o, 1'b0);
        chk("arst.q", bus1.q_o, 32'h0);
        chk("arst.ds", bus1.ds_o, 32'h0);
        ack1 = 1'b1;
        cycle();
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after release: only periodic updates on the 8-cycle instance
        rise0 = 0;
        rise1 = 0;
        prev0 = 1'b0;
        prev1 = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (n == 6) ack1 = 1'b0;
            cycle();
            if (bus0.upd_req_o && !prev0) rise0++;
            if (bus1.upd_req_o && !prev1) rise1++;
            prev0 = bus0.upd_req_o;
            prev1 = bus1.upd_req_o;
        end
        chk("per.rises8", rise0, 32'd4);
        chk("per.rises0", rise1, 32'd0);

        // Random traffic
        auto0 = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                if (!req) wdata = $urandom;
                req = ~req;
            end
            de   = ($urandom_range(0, 2) == 0);
            d    = $urandom_range(0, 3);
            ack0 = 1'(($urandom_range(0, 1)));
            ack1 = 1'(($urandom_range(0, 1)));
            cycle();
        end

        // Request held high through reset counts as a fresh write
        de    = 1'b0;
        ack0  = 1'b0;
        ack1  = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        req   = 1'b1;
        wdata = 32'hC0DE_0001;
        #1;
        cmp_all();
        cycle();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("rel.q", bus1.q_o, 32'hC0DE_0001);
        chk1("rel.qe", bus1.qe_o, 1'b1);
        chk1("rel.ack", bus1.ack_o, 1'b1);
        req = 1'b0;
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
